// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like bus port between instruction fetch (inst_*) and
// load/store (data_*). Data has priority; after STARVE_LIMIT consecutive data grants
// with a fetch waiting, the fetch is forced through.
// Latency: the winner's *_addr_ok is combinational in the grant cycle. mem_req follows
// one cycle later, and *_data_ok arrives in the same cycle as mem_data_ok.
// Backpressure: one transaction is outstanding at a time. The loser holds *_req until
// granted, and bus stalls (mem_addr_ok / mem_data_ok low) hold REQ/RESP with fields stable.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   inst_* / data_*     - requester request fields in; addr_ok / data_ok / rdata out
//   cancel              - pipeline flush; swallows the response of an outstanding fetch
//   mem_*               - unified bus request out; mem_addr_ok / mem_data_ok / mem_rdata in
module sram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        cancel,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;     // 0 = inst, 1 = data
  logic        r_discard;   // outstanding fetch was flushed; swallow its response
  logic [3:0]  r_scnt;      // consecutive data grants taken while a fetch was waiting

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  logic        w_grant_inst;
  logic        w_grant_data;
  logic        w_resp_done;
  logic        w_inst_done;
  logic        w_data_done;

  // Next-state and grant decision. Reset suppresses every pulse so that a grant
  // is never signalled for a request the reset is about to throw away.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    w_resp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (inst_req && (!data_req || (r_scnt == LIMIT))) begin
          w_grant_inst = 1'b1;
          w_state_nxt  = S_REQ;
        end else if (data_req) begin
          w_grant_data = 1'b1;
          w_state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_addr_ok) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_data_ok) begin
          w_resp_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (rst) begin
      w_state_nxt  = S_IDLE;
      w_grant_inst = 1'b0;
      w_grant_data = 1'b0;
      w_resp_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= 1'b0;
      r_discard <= 1'b0;
      r_scnt    <= 4'd0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= 32'd0;
      r_wstrb   <= 4'd0;
      r_wdata   <= 32'd0;
    end else begin
      if (w_grant_inst) begin
        r_owner <= 1'b0;
        r_wr    <= inst_wr;
        r_size  <= inst_size;
        r_addr  <= inst_addr;
        r_wstrb <= inst_wstrb;
        r_wdata <= inst_wdata;
        r_scnt  <= 4'd0;
      end else if (w_grant_data) begin
        r_owner <= 1'b1;
        r_wr    <= data_wr;
        r_size  <= data_size;
        r_addr  <= data_addr;
        r_wstrb <= data_wstrb;
        r_wdata <= data_wdata;
        // Only grants that bypass a waiting fetch count towards starvation.
        if (!inst_req) begin
          r_scnt <= 4'd0;
        end else if (r_scnt != LIMIT) begin
          r_scnt <= r_scnt + 4'd1;
        end
      end

      // A flush in the grant cycle itself is not recorded: that grant is
      // already the post-flush fetch, and the FSM is still in IDLE then.
      if (w_resp_done) begin
        r_discard <= 1'b0;
      end else if (cancel && !r_owner && (r_state != S_IDLE)) begin
        r_discard <= 1'b1;
      end
    end
  end

  // cancel arriving together with the response must still swallow it.
  assign w_inst_done  = w_resp_done && !r_owner && !(r_discard || cancel);
  assign w_data_done  = w_resp_done && r_owner;

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;
  assign inst_data_ok = w_inst_done;
  assign data_data_ok = w_data_done;
  assign inst_rdata   = w_inst_done ? mem_rdata : 32'd0;
  assign data_rdata   = w_data_done ? mem_rdata : 32'd0;

  assign mem_req      = (r_state == S_REQ);
  assign mem_wr       = r_wr;
  assign mem_size     = r_size;
  assign mem_addr     = r_addr;
  assign mem_wstrb    = r_wstrb;
  assign mem_wdata    = r_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios followed by randomized traffic against sram_arbiter.
// A bus-slave process pushes each response it issues into a queue. A monitor process keeps
// a transaction-level reference model and compares every DUT output each cycle at negedge.
module tb_sram_arbiter;
  localparam int LIM = 4;

  logic        clk, rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        cancel;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  int checks = 0;
  int errors = 0;

  bus_t        exp_bus_q[$];
  logic [31:0] resp_q[$];
  bit          grant_log[$];   // 1 = data grant, 0 = inst grant

  // reference model state
  bit m_busy, m_acc, m_owner, m_disc;
  int m_streak;
  bit g_inst_acc, g_data_acc;

  // bus slave knobs
  int          p_aok = 100;
  int          p_dok = 100;
  bit          spur = 0;
  bit          fix_en = 0;
  logic [31:0] fix_val = 32'd0;
  bit          sl_pend = 0;

  sram_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .cancel(cancel),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a DUT pulse; lat is the negedge count at which it was seen, 0 on timeout.
  task automatic wait_for(input int sel, input int maxc, output int lat);
    logic s;
    lat = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      case (sel)
        0:       s = inst_addr_ok;
        1:       s = data_addr_ok;
        2:       s = inst_data_ok;
        default: s = data_data_ok;
      endcase
      if (s) begin
        lat = k;
        break;
      end
      cyc();
    end
  endtask

  // Requesters: hold a request until it is accepted, then maybe issue a new one.
  task automatic drive_reqs(input int pi, input int pd, input int pc);
    if (inst_req && g_inst_acc) inst_req = 1'b0;
    if (data_req && g_data_acc) data_req = 1'b0;
    if (!inst_req && (int'($urandom_range(99)) < pi)) begin
      inst_req   = 1'b1;
      inst_wr    = 1'($urandom_range(1));
      inst_size  = 2'($urandom_range(2));
      inst_addr  = $urandom;
      inst_wstrb = 4'($urandom);
      inst_wdata = $urandom;
    end
    if (!data_req && (int'($urandom_range(99)) < pd)) begin
      data_req   = 1'b1;
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(2));
      data_addr  = $urandom;
      data_wstrb = 4'($urandom);
      data_wdata = $urandom;
    end
    cancel = (int'($urandom_range(99)) < pc);
  endtask

  // Bus slave: drives handshakes at posedge+2 and records every real response it issues.
  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      mem_rdata   = $urandom;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (mem_req) mem_addr_ok = (int'($urandom_range(99)) < p_aok);
      else if (spur) mem_addr_ok = (int'($urandom_range(99)) < 10);
      if (sl_pend) begin
        if (int'($urandom_range(99)) < p_dok) begin
          mem_data_ok = 1'b1;
          if (fix_en) mem_rdata = fix_val;
          if (mem_wr) mem_rdata = 32'd0;
          resp_q.push_back(mem_rdata);
        end
      end else if (spur) begin
        mem_data_ok = (int'($urandom_range(99)) < 10);
      end
      @(negedge clk);
      if (rst) sl_pend = 1'b0;
      else if (mem_req && mem_addr_ok) sl_pend = 1'b1;
      else if (sl_pend && mem_data_ok) sl_pend = 1'b0;
    end
  end

  // Monitor with transaction-level reference model.
  initial begin
    bus_t        eb;
    logic [31:0] rd;
    bit          egi, egd, eid, edd, done;
    m_busy = 0; m_acc = 0; m_owner = 0; m_disc = 0; m_streak = 0;
    g_inst_acc = 0; g_data_acc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_acc = 0; m_disc = 0; m_streak = 0;
        exp_bus_q.delete();
        resp_q.delete();
        g_inst_acc = 0; g_data_acc = 0;
      end else begin
        egi = 0; egd = 0;
        if (!m_busy) begin
          if (inst_req && (!data_req || m_streak >= LIM)) egi = 1;
          else if (data_req) egd = 1;
        end
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(egi));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(egd));

        chk("mem_req", 32'(mem_req), 32'(m_busy && !m_acc));
        if (m_busy && !m_acc && mem_req) begin
          if (exp_bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_fields: got a request, want none queued at %0t", $time);
          end else begin
            eb = exp_bus_q[0];
            chk("mem_wr",    32'(mem_wr),    32'(eb.wr));
            chk("mem_size",  32'(mem_size),  32'(eb.size));
            chk("mem_addr",  mem_addr,       eb.addr);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(eb.wstrb));
            chk("mem_wdata", mem_wdata,      eb.wdata);
          end
        end

        eid = 0; edd = 0; rd = 32'd0; done = 0;
        if (m_acc && mem_data_ok) begin
          done = 1;
          if (resp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_queue: got a response, want a queued one at %0t", $time);
          end else begin
            rd = resp_q.pop_front();
          end
          if (m_owner) edd = 1;
          else eid = !(m_disc || cancel);
        end
        chk("inst_data_ok", 32'(inst_data_ok), 32'(eid));
        chk("data_data_ok", 32'(data_data_ok), 32'(edd));
        chk("inst_rdata", inst_rdata, eid ? rd : 32'd0);
        chk("data_rdata", data_rdata, edd ? rd : 32'd0);

        if (m_busy && !m_owner && cancel) m_disc = 1;
        if (done) begin
          m_busy = 0; m_acc = 0; m_disc = 0;
        end else if (m_busy && !m_acc && mem_addr_ok) begin
          m_acc = 1;
          if (exp_bus_q.size() != 0) eb = exp_bus_q.pop_front();
        end
        if (egi || egd) begin
          m_busy  = 1;
          m_owner = egd;
          grant_log.push_back(egd);
          if (egi) eb = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
          else     eb = {data_wr, data_size, data_addr, data_wstrb, data_wdata};
          exp_bus_q.push_back(eb);
          if (egi || !inst_req) m_streak = 0;
          else m_streak = (m_streak < LIM) ? m_streak + 1 : LIM;
        end
        g_inst_acc = inst_addr_ok;
        g_data_acc = data_addr_ok;
      end
    end
  end

  initial begin
    int lat;
    int cnt;
    bit exp_seq[10];
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rst = 1'b1; cancel = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_mem_req",   32'(mem_req), 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_ctl",   32'({mem_wr, mem_size, mem_wstrb}), 0);
    chk("rst_oks",       32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 0);

    // single fetch with minimum latency
    cyc();
    fix_en = 1; fix_val = 32'h02800C0C;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h1C000000; inst_wstrb = 0; inst_wdata = 0;
    @(negedge clk);
    chk("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
    cyc(); inst_req = 0;
    @(negedge clk);
    chk("t1_mem_req",  32'(mem_req), 1);
    chk("t1_mem_addr", mem_addr, 32'h1C000000);
    cyc();
    @(negedge clk);
    chk("t1_inst_data_ok", 32'(inst_data_ok), 1);
    chk("t1_inst_rdata",   inst_rdata, 32'h02800C0C);
    cyc(); cyc();

    // simultaneous requests: data first, inst in the following IDLE
    cyc();
    inst_req = 1; inst_addr = 32'h1C000040;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000010; data_wstrb = 0; data_wdata = 0;
    @(negedge clk);
    chk("t2_data_wins", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
    cyc(); data_req = 0;
    wait_for(0, 8, lat);
    chk("t2_inst_next_idle", lat, 3);
    cyc(); inst_req = 0;
    repeat (4) cyc();

    // both requesters held: anti-starvation order
    grant_log.delete();
    for (int k = 0; k < 200 && grant_log.size() < 10; k++) begin
      cyc();
      drive_reqs(100, 100, 0);
    end
    cyc(); inst_req = 0; data_req = 0;
    chk("t3_grant_count", 32'(grant_log.size() >= 10), 1);
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      chk($sformatf("t3_grant_%0d", k), 32'(grant_log[k]), 32'(exp_seq[k]));
    repeat (6) cyc();

    // cancel during RESP swallows the fetch response
    cyc();
    p_dok = 0; fix_val = 32'hDEADBEEF;
    inst_req = 1; inst_wr = 0; inst_addr = 32'h1C004000;
    @(negedge clk);
    cyc(); inst_req = 0;
    cyc();
    cyc(); cancel = 1;
    cyc(); cancel = 0; p_dok = 100;
    @(negedge clk);
    chk("t4_inst_data_ok", 32'(inst_data_ok), 0);
    chk("t4_inst_rdata",   inst_rdata, 0);
    cyc(); fix_val = 32'h11223344;
    inst_req = 1; inst_addr = 32'h1C008000;
    wait_for(0, 4, lat);
    chk("t4_refetch_grant", lat, 1);
    cyc(); inst_req = 0;
    wait_for(2, 10, lat);
    chk("t4_refetch_done", lat, 2);
    chk("t4_refetch_rdata", inst_rdata, 32'h11223344);
    repeat (3) cyc();

    // bus stall during a store
    cyc();
    p_aok = 0; fix_en = 0;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80001000;
    data_wstrb = 4'hF; data_wdata = 32'h12345678;
    @(negedge clk);
    chk("t5_grant", 32'(data_addr_ok), 1);
    cyc(); data_req = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_stall_req",   32'(mem_req), 1);
      chk("t5_stall_addr",  mem_addr, 32'h80001000);
      chk("t5_stall_wdata", mem_wdata, 32'h12345678);
      chk("t5_stall_ctl",   32'({mem_wr, mem_size, mem_wstrb}), 32'({1'b1, 2'd2, 4'hF}));
      if (k < 4) cyc();
    end
    cyc(); p_aok = 100;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (data_data_ok) cnt++;
      cyc();
    end
    chk("t5_data_ok_pulses", cnt, 1);

    // reset while in RESP
    cyc();
    p_dok = 0;
    inst_req = 1; inst_wr = 0; inst_addr = 32'h1C000100;
    @(negedge clk);
    cyc(); inst_req = 0;
    cyc();
    cyc(); rst = 1;
    cyc(); rst = 0;
    @(negedge clk);
    chk("t6_mem_req",   32'(mem_req), 0);
    chk("t6_mem_addr",  mem_addr, 0);
    chk("t6_mem_wdata", mem_wdata, 0);
    chk("t6_mem_ctl",   32'({mem_wr, mem_size, mem_wstrb}), 0);
    chk("t6_oks",       32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 0);
    chk("t6_rdata",     inst_rdata | data_rdata, 0);
    cyc(); p_dok = 100;
    data_req = 1; data_wr = 0; data_addr = 32'h80002000;
    wait_for(1, 4, lat);
    chk("t6_fresh_grant", lat, 1);
    cyc(); data_req = 0;
    wait_for(3, 10, lat);
    chk("t6_fresh_done", lat, 2);
    repeat (3) cyc();

    // randomized traffic with stalls, spurious handshakes and flushes
    spur = 1; p_aok = 60; p_dok = 50;
    repeat (3000) begin
      cyc();
      drive_reqs(40, 50, 8);
    end
    spur = 0; p_aok = 100; p_dok = 100;
    for (int k = 0; k < 50; k++) begin
      cyc();
      drive_reqs(0, 0, 0);
    end
    chk("drain_reqs", 32'({inst_req, data_req}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
